// File: rtl/nano_dsi_data.sv
`default_nettype none
// ============================================================================
// Module   : nano_dsi_data
// Function : D-PHY HS data-lane driver. Runs the LP11->LP01->LP00->HS entry,
//            sends sync 0xB8 and an LSB-first payload, then HS-trail and exit.
//            Define NANO_DSI_DATA_EOT_EN to append the EoT short packet.
// Revision : 1.0 - initial release
// ============================================================================
module nano_dsi_data (
  input  logic       clk,
  input  logic       rst,
  output logic       data_lp_p,
  output logic       data_lp_n,
  output logic       data_hs_p,
  output logic       data_hs_n,
  input  logic       clk_rdy,
  input  logic       clk_sync,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic       err_underrun,
  input  logic       err_clr,
  input  logic [7:0] cfg_lpx,
  input  logic [7:0] cfg_hs_prep,
  input  logic [7:0] cfg_hs_zero,
  input  logic [7:0] cfg_hs_trail
);

  typedef enum logic [3:0] {
    ST_LP11     = 4'd0,
    ST_LP01     = 4'd1,
    ST_LP00     = 4'd2,
    ST_HS_ZERO  = 4'd3,
    ST_HS_ALIGN = 4'd4,
    ST_HS_SYNC  = 4'd5,
    ST_HS_DATA  = 4'd6,
`ifdef NANO_DSI_DATA_EOT_EN
    ST_HS_EOT   = 4'd7,
`endif
    ST_HS_TRAIL = 4'd8
  } state_t;

  localparam logic [7:0] c_sync_byte = 8'hB8;
  localparam logic [7:0] c_untimed   = 8'h80;
`ifdef NANO_DSI_DATA_EOT_EN
  localparam logic [31:0] c_eot_word = 32'h010F0F08;
`endif

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic       last_q, last_d;
  logic       err_q, err_d;
  logic       tx_last_q, tx_last_d;
  logic       lp_p_q, lp_p_d;
  logic       lp_n_q, lp_n_d;
  logic       hs_p_q, hs_p_d;
  logic       hs_n_q, hs_n_d;
  logic       busy_q, busy_d;
`ifdef NANO_DSI_DATA_EOT_EN
  logic [1:0] eot_idx_q, eot_idx_d;
`endif

  logic trig, at_bit7, ready, accept, underrun;
  logic tx_bit, hs_active, serialising;

  always_comb begin
    trig     = timer_q[7];
    at_bit7  = (bit_q == 3'd7);
    ready    = at_bit7 && ((state_q == ST_HS_SYNC) ||
                           ((state_q == ST_HS_DATA) && !last_q));
    accept   = ready && in_valid;
    underrun = ready && !in_valid;

    state_d = state_q;
    case (state_q)
      ST_LP11:     if (in_valid && clk_rdy) state_d = ST_LP01;
      ST_LP01:     if (trig) state_d = ST_LP00;
      ST_LP00:     if (trig) state_d = ST_HS_ZERO;
      ST_HS_ZERO:  if (trig) state_d = ST_HS_ALIGN;
      ST_HS_ALIGN: if (!clk_sync) state_d = ST_HS_SYNC;
      ST_HS_SYNC:  if (at_bit7) state_d = accept ? ST_HS_DATA : ST_HS_TRAIL;
      ST_HS_DATA: begin
        // At bit 7 without a new byte it is either an underrun or the end of burst.
        if (at_bit7 && !accept) begin
`ifdef NANO_DSI_DATA_EOT_EN
          state_d = underrun ? ST_HS_TRAIL : ST_HS_EOT;
`else
          state_d = ST_HS_TRAIL;
`endif
        end
      end
`ifdef NANO_DSI_DATA_EOT_EN
      ST_HS_EOT:   if (at_bit7 && (eot_idx_q == 2'd3)) state_d = ST_HS_TRAIL;
`endif
      ST_HS_TRAIL: if (trig) state_d = ST_LP11;
      default:     state_d = ST_LP11;
    endcase

    if (state_d != state_q) begin
      case (state_d)
        ST_LP01:     timer_d = cfg_lpx;
        ST_LP00:     timer_d = cfg_hs_prep;
        ST_HS_ZERO:  timer_d = cfg_hs_zero;
        ST_HS_TRAIL: timer_d = cfg_hs_trail;
        default:     timer_d = c_untimed;
      endcase
      bit_d = 3'd0;
    end else begin
      timer_d = timer_q - 8'd1;
      bit_d   = bit_q + 3'd1;
    end

`ifdef NANO_DSI_DATA_EOT_EN
    if (state_q != ST_HS_EOT) eot_idx_d = 2'd0;
    else if (at_bit7)         eot_idx_d = eot_idx_q + 2'd1;
    else                      eot_idx_d = eot_idx_q;
`endif

    byte_d = accept ? in_data : byte_q;
    if (accept)                 last_d = in_last;
    else if (state_q == ST_LP11) last_d = 1'b0;
    else                        last_d = last_q;

    err_d = underrun || (err_q && !err_clr);

    serialising = (state_q == ST_HS_SYNC) || (state_q == ST_HS_DATA);
    case (state_q)
      ST_HS_SYNC:  tx_bit = c_sync_byte[bit_q];
      ST_HS_DATA:  tx_bit = byte_q[bit_q];
`ifdef NANO_DSI_DATA_EOT_EN
      ST_HS_EOT:   tx_bit = c_eot_word[{eot_idx_q, bit_q}];
`endif
      ST_HS_TRAIL: tx_bit = !tx_last_q;
      default:     tx_bit = 1'b0;
    endcase
`ifdef NANO_DSI_DATA_EOT_EN
    serialising = serialising || (state_q == ST_HS_EOT);
`endif
    tx_last_d = serialising ? tx_bit : tx_last_q;

    hs_active = (state_q != ST_LP11) && (state_q != ST_LP01) && (state_q != ST_LP00);
    lp_p_d    = (state_q == ST_LP11);
    lp_n_d    = (state_q == ST_LP11) || (state_q == ST_LP01);
    hs_p_d    = hs_active && tx_bit;
    hs_n_d    = hs_active && !tx_bit;
    busy_d    = (state_q != ST_LP11);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LP11;
      timer_q   <= c_untimed;
      bit_q     <= 3'd0;
      byte_q    <= 8'h00;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      tx_last_q <= 1'b0;
      lp_p_q    <= 1'b1;
      lp_n_q    <= 1'b1;
      hs_p_q    <= 1'b0;
      hs_n_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef NANO_DSI_DATA_EOT_EN
      eot_idx_q <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      err_q     <= err_d;
      tx_last_q <= tx_last_d;
      lp_p_q    <= lp_p_d;
      lp_n_q    <= lp_n_d;
      hs_p_q    <= hs_p_d;
      hs_n_q    <= hs_n_d;
      busy_q    <= busy_d;
`ifdef NANO_DSI_DATA_EOT_EN
      eot_idx_q <= eot_idx_d;
`endif
    end
  end

  assign data_lp_p    = lp_p_q;
  assign data_lp_n    = lp_n_q;
  assign data_hs_p    = hs_p_q;
  assign data_hs_n    = hs_n_q;
  assign in_ready     = ready;
  assign busy         = busy_q;
  assign err_underrun = err_q;

endmodule
`default_nettype wire

// File: tb/tb_nano_dsi_data.sv
`default_nettype none
// ============================================================================
// Module   : tb_nano_dsi_data
// Function : Self-checking bench for nano_dsi_data: directed vector table,
//            hand sequences and randomized bursts against a waveform model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nano_dsi_data;

  logic       clk, rst;
  logic       data_lp_p, data_lp_n, data_hs_p, data_hs_n;
  logic       clk_rdy, clk_sync;
  logic [7:0] in_data;
  logic       in_last, in_valid, in_ready, busy, err_underrun, err_clr;
  logic [7:0] cfg_lpx, cfg_hs_prep, cfg_hs_zero, cfg_hs_trail;

  nano_dsi_data dut (
    .clk(clk), .rst(rst),
    .data_lp_p(data_lp_p), .data_lp_n(data_lp_n),
    .data_hs_p(data_hs_p), .data_hs_n(data_hs_n),
    .clk_rdy(clk_rdy), .clk_sync(clk_sync),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .err_underrun(err_underrun), .err_clr(err_clr),
    .cfg_lpx(cfg_lpx), .cfg_hs_prep(cfg_hs_prep),
    .cfg_hs_zero(cfg_hs_zero), .cfg_hs_trail(cfg_hs_trail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] lpx, prep, hz, tr;
    int         n, k;
    logic [7:0] b0, b1, b2;
    logic       exp_err;
    int         exp_pulses;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] drv_bytes [8];
  int         drv_n, drv_k, drv_idx, cyc_idx;
  bit         drv_active, recording, clr_req, clr_uf;
  logic [5:0] trace [$];
  logic       cs_trace [$];
  logic [7:0] acc_q [$];
  logic [5:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs just after the edge, then drive this cycle's inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    clk_sync = ~clk_sync;
    if (drv_active) begin
      if (drv_idx < drv_n && !(drv_k >= 0 && drv_idx >= drv_k && cyc_idx > 0)) begin
        in_valid = 1'b1;
        in_data  = drv_bytes[drv_idx];
        in_last  = (drv_idx == drv_n - 1);
      end else begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
      end
    end
    err_clr = clr_req || (clr_uf && in_ready && !in_valid);
    clr_req = 1'b0;
    if (in_valid && in_ready) begin
      acc_q.push_back(in_data);
      drv_idx++;
    end
    if (recording) begin
      trace.push_back({data_lp_p, data_lp_n, data_hs_p, data_hs_n, busy, in_ready});
      cs_trace.push_back(clk_sync);
    end
    cyc_idx++;
  endtask

  // Expected per-cycle {lp_p, lp_n, hs_p, hs_n, busy, in_ready} from the lane protocol.
  task automatic build_exp(input int lpx, input int prep, input int hz, input int tr,
                           input int n, input int k);
    logic [7:0] grp [$];
    logic       grp_rdy [$];
    logic [7:0] g;
    logic       b, last_b;
    int         nsent, zs;
    logic [7:0] eot [4];
    eot = '{8'h08, 8'h0F, 8'h0F, 8'h01};
    exp_q.delete();
    grp.push_back(8'hB8);
    grp_rdy.push_back(1'b1);
    nsent = (k >= 0) ? k : n;
    for (int i = 0; i < nsent; i++) begin
      grp.push_back(drv_bytes[i]);
      grp_rdy.push_back((k >= 0) || (i != n - 1));
    end
`ifdef NANO_DSI_DATA_EOT_EN
    if (k < 0) for (int i = 0; i < 4; i++) begin
      grp.push_back(eot[i]);
      grp_rdy.push_back(1'b0);
    end
`endif
    repeat (2)        exp_q.push_back(6'b110000);
    repeat (lpx + 2)  exp_q.push_back(6'b010010);
    repeat (prep + 2) exp_q.push_back(6'b000010);
    zs = exp_q.size();
    while (exp_q.size() < cs_trace.size() &&
           (exp_q.size() < zs + hz + 3 || cs_trace[exp_q.size()] !== 1'b0))
      exp_q.push_back(6'b000110);
    last_b = 1'b0;
    for (int gi = 0; gi < grp.size(); gi++) begin
      g = grp[gi];
      for (int bi = 0; bi < 8; bi++) begin
        b = g[bi];
        exp_q.push_back({2'b00, b, ~b, 1'b1, (bi == 6) && grp_rdy[gi]});
        last_b = b;
      end
    end
    repeat (tr + 2) exp_q.push_back({2'b00, ~last_b, last_b, 1'b1, 1'b0});
    while (exp_q.size() < trace.size()) exp_q.push_back(6'b110000);
  endtask

  task automatic run_burst(input string name, input logic [7:0] lpx, input logic [7:0] prep,
                           input logic [7:0] hz, input logic [7:0] tr, input int n, input int k,
                           input bit cuf, input logic exp_err, input int exp_pulses);
    int  len, mism, pulses, nsent;
    bit  acc_ok;
    cfg_lpx = lpx; cfg_hs_prep = prep; cfg_hs_zero = hz; cfg_hs_trail = tr;
    clr_req = 1'b1;
    cyc();
    cyc();
    trace.delete(); cs_trace.delete(); acc_q.delete();
    drv_n = n; drv_k = k; drv_idx = 0; cyc_idx = 0; clr_uf = cuf;
    drv_active = 1'b1; recording = 1'b1;
    len = 16 + int'(lpx) + int'(prep) + int'(hz) + int'(tr) + 8 * (n + 6);
    repeat (len) cyc();
    recording = 1'b0; drv_active = 1'b0; clr_uf = 1'b0; in_valid = 1'b0;
    build_exp(int'(lpx), int'(prep), int'(hz), int'(tr), n, k);

    mism = -1;
    pulses = 0;
    for (int i = 0; i < trace.size(); i++) begin
      if (mism < 0 && (i >= exp_q.size() || trace[i] !== exp_q[i])) mism = i;
      if (trace[i][0]) pulses++;
    end
    n_cmp++;
    if (mism >= 0 || exp_q.size() != trace.size()) begin
      n_bad++;
      if (mism >= 0 && mism < exp_q.size())
        $display("FAIL %s waveform: cycle %0d got %b, expected %b", name, mism, trace[mism], exp_q[mism]);
      else
        $display("FAIL %s waveform: length got %0d, expected %0d", name, trace.size(), exp_q.size());
    end
    check($sformatf("%s err_underrun", name), {31'd0, err_underrun}, {31'd0, exp_err});
    check($sformatf("%s ready_pulses", name), pulses, exp_pulses);
    nsent = (k >= 0) ? k : n;
    acc_ok = (acc_q.size() == nsent);
    for (int i = 0; i < acc_q.size() && i < nsent; i++)
      if (acc_q[i] !== drv_bytes[i]) acc_ok = 1'b0;
    check($sformatf("%s accepted_bytes", name), acc_q.size(), acc_ok ? nsent : 32'hFFFF_FFFF);
  endtask

  vec_t vecs [6];

  initial begin
    rst = 1'b1; clk_rdy = 1'b1; clk_sync = 1'b0; in_data = 8'h00; in_last = 1'b0;
    in_valid = 1'b0; err_clr = 1'b0; cfg_lpx = 8'd0; cfg_hs_prep = 8'd0;
    cfg_hs_zero = 8'd0; cfg_hs_trail = 8'd0;
    drv_active = 1'b0; recording = 1'b0; clr_req = 1'b0; clr_uf = 1'b0;
    drv_n = 0; drv_k = -1; drv_idx = 0; cyc_idx = 0;

    repeat (3) cyc();
    check("reset pins", {data_lp_p, data_lp_n, data_hs_p, data_hs_n}, 4'b1100);
    check("reset busy_ready_err", {busy, in_ready, err_underrun}, 3'b000);
    rst = 1'b0;
    repeat (2) cyc();

    vecs[0] = '{8'd3,   8'd4,   8'd10,  8'd6,   1, -1, 8'hA5, 8'h00, 8'h00, 1'b0, 1};
    vecs[1] = '{8'd0,   8'd0,   8'd0,   8'd0,   3, -1, 8'h01, 8'h02, 8'h03, 1'b0, 3};
    vecs[2] = '{8'd2,   8'd1,   8'd5,   8'd3,   3,  1, 8'h11, 8'h22, 8'h33, 1'b1, 2};
    vecs[3] = '{8'd1,   8'd1,   8'd1,   8'd1,   2,  0, 8'h5A, 8'hC3, 8'h00, 1'b1, 1};
    vecs[4] = '{8'd127, 8'd127, 8'd127, 8'd127, 2, -1, 8'hFF, 8'h00, 8'h00, 1'b0, 2};
    vecs[5] = '{8'd5,   8'd3,   8'd2,   8'd9,   1, -1, 8'h55, 8'h00, 8'h00, 1'b0, 1};
    for (int v = 0; v < 6; v++) begin
      drv_bytes[0] = vecs[v].b0; drv_bytes[1] = vecs[v].b1; drv_bytes[2] = vecs[v].b2;
      run_burst($sformatf("vec%0d", v), vecs[v].lpx, vecs[v].prep, vecs[v].hz, vecs[v].tr,
                vecs[v].n, vecs[v].k, 1'b0, vecs[v].exp_err, vecs[v].exp_pulses);
    end

    // Underrun flag set in the same cycle as err_clr: the set must win.
    drv_bytes[0] = 8'h3C; drv_bytes[1] = 8'h96;
    run_burst("set_vs_clr", 8'd1, 8'd2, 8'd3, 8'd2, 2, 1, 1'b1, 1'b1, 2);

    // Reset in the middle of HS_DATA, with the sticky error still set.
    cfg_lpx = 8'd1; cfg_hs_prep = 8'd1; cfg_hs_zero = 8'd1; cfg_hs_trail = 8'd1;
    drv_bytes[0] = 8'hF0; drv_bytes[1] = 8'h0F; drv_bytes[2] = 8'hAA; drv_bytes[3] = 8'h55;
    drv_n = 4; drv_k = -1; drv_idx = 0; cyc_idx = 0; drv_active = 1'b1;
    repeat (30) cyc();
    check("pre_reset in HS", {data_lp_p, data_lp_n, busy}, 3'b001);
    drv_active = 1'b0; in_valid = 1'b0; rst = 1'b1;
    cyc();
    check("midreset pins", {data_lp_p, data_lp_n, data_hs_p, data_hs_n}, 4'b1100);
    check("midreset busy_ready_err", {busy, in_ready, err_underrun}, 3'b000);
    rst = 1'b0;
    repeat (40) cyc();
    check("post_reset idle", {data_lp_p, data_lp_n, busy}, 3'b110);

    // Underrun then an explicit err_clr pulse.
    drv_bytes[0] = 8'h81; drv_bytes[1] = 8'h42;
    run_burst("underrun_clr", 8'd2, 8'd2, 8'd2, 8'd2, 2, 1, 1'b0, 1'b1, 2);
    clr_req = 1'b1;
    cyc();
    cyc();
    check("err_clr clears", {31'd0, err_underrun}, 32'd0);

    // clk_rdy low keeps the lane in LP11 even with data offered.
    clk_rdy = 1'b0; in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
    repeat (10) cyc();
    check("clk_rdy gate", {data_lp_p, data_lp_n, busy, in_ready}, 4'b1100);
    in_valid = 1'b0; in_last = 1'b0; clk_rdy = 1'b1;
    repeat (2) cyc();

    for (int r = 0; r < 16; r++) begin
      logic [7:0] lpx, prep, hz, tr;
      int n, k;
      lpx = 8'($urandom_range(0, 12)); prep = 8'($urandom_range(0, 12));
      hz = 8'($urandom_range(0, 12)); tr = 8'($urandom_range(0, 12));
      n = int'($urandom_range(1, 4));
      k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      for (int i = 0; i < 8; i++) drv_bytes[i] = 8'($urandom);
      run_burst($sformatf("rand%0d", r), lpx, prep, hz, tr, n, k, 1'b0,
                (k >= 0), (k >= 0) ? k + 1 : n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
